// File: rtl/multi_shift_register.sv
// Parametrised register with active-low parallel load and a one-bit-per-clock multi-bit shift engine.
// Define MULTI_SHIFT_REGISTER_SERIAL_IN_EN to add a serial_in port that supplies the logical/left-shift fill bit.
module multi_shift_register #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] amount,
`ifdef MULTI_SHIFT_REGISTER_SERIAL_IN_EN
   input  logic             serial_in,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LOGICAL = 2'b00;
   localparam logic [1:0] MODE_ARITH   = 2'b01;
   localparam logic [1:0] MODE_ROTATE  = 2'b10;

   state_t             r_state;
   logic [WIDTH-1:0]   r_q;
   logic               r_dir;
   logic [1:0]         r_mode;
   logic [AMT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               w_fill;
   logic [WIDTH-1:0]   w_stepped;

`ifdef MULTI_SHIFT_REGISTER_SERIAL_IN_EN
   assign w_fill = serial_in;
`else
   assign w_fill = 1'b0;
`endif

   // One single-bit step of the latched command; hold (mode 11) leaves q alone.
   always_comb begin
      w_stepped = r_q;
      case (r_mode)
         MODE_LOGICAL: w_stepped = r_dir ? {w_fill, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_fill};
         MODE_ARITH:   w_stepped = r_dir ? {r_q[WIDTH-1], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_fill};
         MODE_ROTATE:  w_stepped = r_dir ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         default:      w_stepped = r_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_dir   <= 1'b0;
         r_mode  <= 2'b00;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (!load_n) begin
                  r_q     <= data_in;
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else if (start) begin
                  r_dir  <= dir;
                  r_mode <= mode;
                  r_cnt  <= amount;
                  if (amount == '0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            SHIFT: begin
               r_q   <= w_stepped;
               r_cnt <= r_cnt - AMT_W'(1);
               // The count never reaches zero here because entry requires a non-zero amount.
               if (r_cnt == AMT_W'(1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign q    = r_q;

endmodule

// File: tb/tb_multi_shift_register.sv
// Self-checking bench for multi_shift_register (default build, WIDTH=8, AMT_W=4).
// Table-driven shift commands plus hand-written sequences for reset, latency, priority and busy-time corners.
module tb_multi_shift_register;

   logic       clock;
   logic       resetn;
   logic       load_n;
   logic [7:0] dataIn;
   logic       start;
   logic       dir;
   logic [1:0] mode;
   logic [3:0] amount;
   logic       busy;
   logic       done;
   logic [7:0] q;

   int totalChecks;
   int badChecks;

   typedef struct {
      logic [7:0] loadVal;
      logic       dir;
      logic [1:0] mode;
      logic [3:0] amount;
      logic [7:0] expQ;
   } vec_t;

   vec_t vectors[12];

   multi_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .load_n  (load_n),
      .data_in (dataIn),
      .start   (start),
      .dir     (dir),
      .mode    (mode),
      .amount  (amount),
      .busy    (busy),
      .done    (done),
      .q       (q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic doLoad(input logic [7:0] val);
      load_n = 1'b0;
      dataIn = val;
      tick();
      load_n = 1'b1;
   endtask

   task automatic applyStimulus(input logic d, input logic [1:0] m, input logic [3:0] a);
      dir    = d;
      mode   = m;
      amount = a;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Called right after the start edge; returns the cycle in which done appears and how many cycles busy was seen.
   task automatic waitDone(output int cycles, output int busyCycles);
      cycles     = 1;
      busyCycles = 0;
      while (!done && cycles < 40) begin
         if (busy) busyCycles++;
         tick();
         cycles++;
      end
   endtask

   initial begin
      int cyc;
      int bcyc;

      totalChecks = 0;
      badChecks   = 0;
      resetn = 1'b0;
      load_n = 1'b1;
      dataIn = 8'h00;
      start  = 1'b0;
      dir    = 1'b0;
      mode   = 2'b00;
      amount = 4'd0;

      vectors[0]  = '{loadVal: 8'hB1, dir: 1'b0, mode: 2'b10, amount: 4'd3,  expQ: 8'h8D};
      vectors[1]  = '{loadVal: 8'hB1, dir: 1'b0, mode: 2'b10, amount: 4'd9,  expQ: 8'h63};
      vectors[2]  = '{loadVal: 8'hFF, dir: 1'b0, mode: 2'b00, amount: 4'd10, expQ: 8'h00};
      vectors[3]  = '{loadVal: 8'h96, dir: 1'b1, mode: 2'b01, amount: 4'd2,  expQ: 8'hE5};
      vectors[4]  = '{loadVal: 8'h96, dir: 1'b1, mode: 2'b00, amount: 4'd3,  expQ: 8'h12};
      vectors[5]  = '{loadVal: 8'h96, dir: 1'b0, mode: 2'b01, amount: 4'd1,  expQ: 8'h2C};
      vectors[6]  = '{loadVal: 8'h96, dir: 1'b1, mode: 2'b10, amount: 4'd2,  expQ: 8'hA5};
      vectors[7]  = '{loadVal: 8'h80, dir: 1'b1, mode: 2'b01, amount: 4'd15, expQ: 8'hFF};
      vectors[8]  = '{loadVal: 8'h5A, dir: 1'b0, mode: 2'b11, amount: 4'd4,  expQ: 8'h5A};
      vectors[9]  = '{loadVal: 8'h7F, dir: 1'b1, mode: 2'b01, amount: 4'd9,  expQ: 8'h00};
      vectors[10] = '{loadVal: 8'h01, dir: 1'b0, mode: 2'b00, amount: 4'd7,  expQ: 8'h80};
      vectors[11] = '{loadVal: 8'hC3, dir: 1'b1, mode: 2'b10, amount: 4'd8,  expQ: 8'hC3};

      // Reset state
      tick();
      tick();
      checkOutput("reset q", 32'(q), 32'h00);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset done", 32'(done), 32'h0);
      resetn = 1'b1;
      tick();

      // Table-driven commands: final value, done cycle and busy length
      for (int i = 0; i < 12; i++) begin
         doLoad(vectors[i].loadVal);
         applyStimulus(vectors[i].dir, vectors[i].mode, vectors[i].amount);
         waitDone(cyc, bcyc);
         checkOutput($sformatf("vec%0d done seen", i), 32'(done), 32'h1);
         checkOutput($sformatf("vec%0d q", i), 32'(q), 32'(vectors[i].expQ));
         checkOutput($sformatf("vec%0d done cycle", i), 32'(cyc), 32'(vectors[i].amount) + 32'd1);
         checkOutput($sformatf("vec%0d busy cycles", i), 32'(bcyc), 32'(vectors[i].amount));
         tick();
         checkOutput($sformatf("vec%0d done pulse", i), 32'(done), 32'h0);
      end

      // Arithmetic right step by step
      doLoad(8'h96);
      applyStimulus(1'b1, 2'b01, 4'd2);
      checkOutput("ar busy c1", 32'(busy), 32'h1);
      checkOutput("ar q c1", 32'(q), 32'h96);
      tick();
      checkOutput("ar busy c2", 32'(busy), 32'h1);
      checkOutput("ar q c2", 32'(q), 32'hCB);
      tick();
      checkOutput("ar busy c3", 32'(busy), 32'h0);
      checkOutput("ar done c3", 32'(done), 32'h1);
      checkOutput("ar q c3", 32'(q), 32'hE5);
      tick();
      checkOutput("ar done c4", 32'(done), 32'h0);

      // Rotate left step by step
      doLoad(8'hB1);
      applyStimulus(1'b0, 2'b10, 4'd3);
      tick();
      checkOutput("rl q1", 32'(q), 32'h63);
      tick();
      checkOutput("rl q2", 32'(q), 32'hC6);
      tick();
      checkOutput("rl q3", 32'(q), 32'h8D);
      checkOutput("rl done", 32'(done), 32'h1);
      tick();

      // Reset in the middle of a shift acts without waiting for an edge
      doLoad(8'hFF);
      applyStimulus(1'b1, 2'b00, 4'd5);
      tick();
      tick();
      checkOutput("mid q before reset", 32'(q), 32'h3F);
      resetn = 1'b0;
      #1;
      checkOutput("mid reset q", 32'(q), 32'h00);
      checkOutput("mid reset busy", 32'(busy), 32'h0);
      checkOutput("mid reset done", 32'(done), 32'h0);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput($sformatf("post reset done %0d", i), 32'(done), 32'h0);
         checkOutput($sformatf("post reset busy %0d", i), 32'(busy), 32'h0);
      end

      // Zero amount: done next cycle, never busy, q unchanged
      doLoad(8'h5A);
      applyStimulus(1'b1, 2'b00, 4'd0);
      checkOutput("zero done", 32'(done), 32'h1);
      checkOutput("zero busy", 32'(busy), 32'h0);
      checkOutput("zero q", 32'(q), 32'h5A);
      tick();
      checkOutput("zero done drop", 32'(done), 32'h0);

      // Load wins over start in the same cycle
      load_n = 1'b0;
      dataIn = 8'h3C;
      dir    = 1'b1;
      mode   = 2'b00;
      amount = 4'd3;
      start  = 1'b1;
      tick();
      load_n = 1'b1;
      start  = 1'b0;
      checkOutput("prio q", 32'(q), 32'h3C);
      checkOutput("prio busy", 32'(busy), 32'h0);
      checkOutput("prio done", 32'(done), 32'h0);
      tick();
      checkOutput("prio busy later", 32'(busy), 32'h0);
      checkOutput("prio done later", 32'(done), 32'h0);
      checkOutput("prio q later", 32'(q), 32'h3C);

      // Load and start are ignored while shifting; a start in the DONE cycle is taken
      doLoad(8'hB1);
      applyStimulus(1'b0, 2'b00, 4'd4);
      tick();
      load_n = 1'b0;
      dataIn = 8'h00;
      start  = 1'b1;
      dir    = 1'b1;
      mode   = 2'b10;
      amount = 4'd0;
      tick();
      load_n = 1'b1;
      start  = 1'b0;
      cyc = 3;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput("ignore done seen", 32'(done), 32'h1);
      checkOutput("ignore done cycle", 32'(cyc), 32'd5);
      checkOutput("ignore q", 32'(q), 32'h10);
      applyStimulus(1'b1, 2'b10, 4'd1);
      checkOutput("b2b busy", 32'(busy), 32'h1);
      tick();
      checkOutput("b2b done", 32'(done), 32'h1);
      checkOutput("b2b q", 32'(q), 32'h08);
      tick();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/multi_shift_register.md
Name: multi_shift_register

Overview:
- Parametrised successor to the 8-bit rotating register.
- Generic WIDTH register with active-low parallel load, plus a command-driven multi-bit shift engine.
- Supported operations: logical shift, arithmetic shift and rotate, in either direction, by a programmable amount.
- Shifts run one bit per clock under an FSM with a start/busy/done handshake; used by lab datapaths that need variable-distance shifts.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of shift-amount field; max amount 2^AMT_W-1 (may exceed WIDTH).

Ports:
- clock  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous active-low reset.
- load_n  in  1  active-low parallel load request.
- data_in  in  WIDTH  parallel load value.
- start  in  1  begin shift command (sampled at clock edge).
- dir  in  1  1 = right, 0 = left.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 hold.
- amount  in  AMT_W  number of single-bit steps.
- busy  out  1  high while shifting.
- done  out  1  one-cycle completion pulse.
- q  out  WIDTH  register contents.

Behaviour:
- Reset: resetn low forces, asynchronously and regardless of state, q=0, busy=0, done=0, state=IDLE, and clears the internal dir/mode/count registers.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE. Both are decoded from registered state, so there are no glitches.
- IDLE or DONE (both accept commands identically):
  - load_n=0: q<=data_in; stay/return to IDLE. load_n has priority over start when both are asserted; start is dropped.
  - start=1 (load_n=1): latch dir, mode, amount.
    - amount=0: next state DONE, q unchanged.
    - otherwise: next state SHIFT, cnt<=amount.
  - DONE with no command: go to IDLE.
- SHIFT: each edge applies one step to q and sets cnt<=cnt-1. When cnt==1 the final step is taken and next state is DONE.
  - Latency: amount N gives N SHIFT cycles; done is high in cycle N+1 after the start edge.
  - Inputs load_n, start, dir, mode, amount and data_in are ignored in SHIFT; the latched command is used.
- Step definitions:
  - logical right: {fill, q[WIDTH-1:1]}.
  - logical left: {q[WIDTH-2:0], fill}.
  - fill=0 unless the optional feature is enabled.
  - arithmetic right: {q[WIDTH-1], q[WIDTH-1:1]}.
  - arithmetic left: identical to logical left.
  - rotate right: {q[0], q[WIDTH-1:1]}.
  - rotate left: {q[WIDTH-2:0], q[WIDTH-1]}.
  - hold: q unchanged; the count still runs, giving a programmable delay.
- Amount greater than or equal to WIDTH: steps continue for the full count. Logical shifts saturate to all-fill; arithmetic right saturates to all-sign; rotate wraps modulo WIDTH.
- Counter is AMT_W bits and is never loaded with 0 in SHIFT, so there is no underflow.

Optional Feature:
- Macro: MULTI_SHIFT_REGISTER_SERIAL_IN_EN.
- Defined:
  - Adds input port serial_in (1 bit).
  - In logical mode, fill = serial_in, sampled at each SHIFT edge.
  - Arithmetic left also uses serial_in as fill.
- Undefined:
  - No serial_in port; fill is constant 0.
- Rotate, arithmetic right and hold are unaffected either way.

Test Plan:
- Reset mid-operation: load 8'hFF, start logical right amount 5, assert resetn=0 after 2 shifts -> q=8'h00, busy=0, done=0 immediately (before next edge). Release -> IDLE, no done pulse.
- Arithmetic right: load 8'b1001_0110, start dir=1 mode=01 amount=2 -> q=8'b1100_1011 then 8'b1110_0101. busy high 2 cycles, done high cycle 3 only.
- Rotate left: load 8'hB1, start dir=0 mode=10 amount=3 -> q=8'h63, 8'hC6, 8'h8D. Also amount=9 from 8'hB1 -> final q=8'h63.
- Over-shift: load 8'hFF, logical left amount 10 -> q=8'h00 after 8th step, stays 8'h00. done in cycle 11.
- Zero amount and priority: start amount=0 -> done next cycle, busy never high, q unchanged. Same-cycle load_n=0 and start=1 with data_in=8'h3C -> q=8'h3C, no busy, no done.
- Ignore while busy: during a 4-step shift, pulse load_n=0 with data_in=8'h00 and pulse start -> result equals the uninterrupted shift. Back-to-back start asserted in the DONE cycle is accepted and busy rises next cycle.
